// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped word cache.
package cache_pkg;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int INDEX_W_DEF = 2;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL,
    WTHRU
  } state_e;
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;
endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate word cache with one
// outstanding CPU transaction and handshaked memory port.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  state_e state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               flush_all, fill, line_we, hit_inc, miss_inc;
  logic [DATA_W-1:0]  line_wdata;

  assign idx = addr_q[INDEX_W-1:0];
  assign tag = addr_q[ADDR_W-1:INDEX_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    flush_all   = 1'b0;
    fill        = 1'b0;
    line_we     = 1'b0;
    line_wdata  = '0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          flush_all = 1'b1;
        end else if (cpu_req) begin
          wr_d    = cpu_wr;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_inc  = hit;
        miss_inc = !hit;
        if (!wr_q && hit) begin
          cpu_rdata_d = data_q[idx];
          cpu_ack_d   = 1'b1;
          state_d     = IDLE;
        end else if (!wr_q) begin
          mem_req_d  = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = addr_q;
          state_d    = FILL;
        end else begin
          // Write-through always goes to memory; a hit also refreshes the line.
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          line_we     = hit;
          line_wdata  = wdata_q;
          state_d     = WTHRU;
        end
      end
      FILL: begin
        if (mem_ack) begin
          line_we     = 1'b1;
          line_wdata  = mem_rdata;
          fill        = 1'b1;
          cpu_rdata_d = mem_rdata;
          cpu_ack_d   = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      WTHRU: begin
        if (mem_ack) begin
          cpu_ack_d = 1'b1;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (flush_all) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  // Line storage has no reset; valid bits alone decide whether it is trusted.
  always_ff @(posedge clk) begin
    if (!rst && line_we) data_q[idx] <= line_wdata;
    if (!rst && fill)    tag_q[idx]  <= tag;
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

  assign cpu_ready = (state_q == IDLE) && !flush;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Randomised bench for dm_cache_ctrl against a resident-address cache model.
module tb_dm_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst, flush, cpu_req, cpu_wr, mem_ack;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdata, mem_rdata;

  logic        cpu_ready, cpu_ack, mem_req, mem_wr;
  logic [31:0] cpu_rdata, mem_wdata;
  logic [4:0]  mem_addr;
  logic [15:0] hit_count, miss_count;

  logic        cpu_ready2, cpu_ack2, mem_req2, mem_wr2;
  logic [31:0] cpu_rdata2, mem_wdata2;
  logic [4:0]  mem_addr2;
  logic [1:0]  hit_count2, miss_count2;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_model [32];
  int          resident [4];
  int          hits, misses;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  dm_cache_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready2),
    .cpu_ack(cpu_ack2), .cpu_rdata(cpu_rdata2), .mem_req(mem_req2), .mem_wr(mem_wr2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count2), .miss_count(miss_count2)
  );

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) resident[i] = -1;
    hits = 0;
    misses = 0;
  endtask

  // One CPU transaction with a memory responder of the given latency; checks inline.
  task automatic access(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                        input int lat, input bit noise);
    int          idx, cyc, wait_c, exp_cyc;
    bit          exp_hit, done, seen_req, acked_mem;
    logic        seen_wr;
    logic [4:0]  seen_addr;
    logic [31:0] seen_wdata, exp_rd;
    idx     = int'(addr) % 4;
    exp_hit = (resident[idx] == int'(addr));
    exp_rd  = mem_model[addr];
    exp_cyc = (exp_hit && !wr) ? 2 : 3 + lat;
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req: got %b want 1", cpu_ready);
    end
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    done = 0; seen_req = 0; acked_mem = 0; wait_c = 0; cyc = 0;
    seen_wr = 1'b0; seen_addr = '0; seen_wdata = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_ack) begin
        mem_ack = 1'b0;
        acked_mem = 1;
      end
      cpu_req = 1'b0;
      if (cpu_ack) begin
        done = 1;
      end else begin
        if (noise && !cpu_ready) begin
          cpu_req = 1'b1; cpu_wr = 1'($urandom); cpu_addr = 5'($urandom); cpu_wdata = $urandom;
        end
        if (mem_req && !acked_mem) begin
          if (!seen_req) begin
            seen_req = 1; seen_wr = mem_wr; seen_addr = mem_addr; seen_wdata = mem_wdata;
          end
          if (wait_c == lat) begin
            mem_ack = 1'b1;
            mem_rdata = seen_wr ? $urandom : mem_model[mem_addr];
          end
          wait_c++;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL ack_timeout: addr=%h wr=%b no cpu_ack within 40 cycles", addr, wr);
      mem_ack = 1'b0;
      return;
    end
    if (exp_hit) hits++; else misses++;
    if (wr) mem_model[addr] = wdata;
    else if (!exp_hit) resident[idx] = int'(addr);
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL latency: addr=%h wr=%b got %0d cycles want %0d", addr, wr, cyc, exp_cyc);
    end
    checks++;
    if (seen_req != (wr || !exp_hit)) begin
      errors++;
      $display("FAIL mem_req_presence: addr=%h got %b want %b", addr, seen_req, wr || !exp_hit);
    end
    if (seen_req) begin
      checks++;
      if (seen_wr !== wr || seen_addr !== addr || (wr && seen_wdata !== wdata)) begin
        errors++;
        $display("FAIL mem_cmd: got wr=%b addr=%h wdata=%h want wr=%b addr=%h wdata=%h",
                 seen_wr, seen_addr, seen_wdata, wr, addr, wdata);
      end
    end
    if (!wr) begin
      checks++;
      if (cpu_rdata !== exp_rd) begin
        errors++;
        $display("FAIL read_data: addr=%h got %h want %h", addr, cpu_rdata, exp_rd);
      end
    end
    checks++;
    if (hit_count !== 16'(sat(hits, 65535)) || miss_count !== 16'(sat(misses, 65535))) begin
      errors++;
      $display("FAIL counters: got hit=%0d miss=%0d want hit=%0d miss=%0d",
               hit_count, miss_count, hits, misses);
    end
    checks++;
    if (hit_count2 !== 2'(sat(hits, 3)) || miss_count2 !== 2'(sat(misses, 3))) begin
      errors++;
      $display("FAIL sat_counters: got hit=%0d miss=%0d want hit=%0d miss=%0d",
               hit_count2, miss_count2, sat(hits, 3), sat(misses, 3));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== '0 || mem_req !== 1'b0 || mem_wr !== 1'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b rdata=%h req=%b wr=%b addr=%h wdata=%h want all 0",
               cpu_ack, cpu_rdata, mem_req, mem_wr, mem_addr, mem_wdata);
    end
    checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0 || cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_counters: hit=%0d miss=%0d ready=%b want 0 0 1",
               hit_count, miss_count, cpu_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] held;
    mem_model[5] = 32'hDEADBEEF;
    access(1'b0, 5'h05, '0, 3, 0);
    held = cpu_rdata;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== held) begin
      errors++;
      $display("FAIL ack_pulse: ack=%b rdata=%h want ack=0 rdata=%h", cpu_ack, cpu_rdata, held);
    end
    checks++;
    if (held !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL first_fill: got %h want deadbeef", held);
    end
    access(1'b0, 5'h05, '0, 1, 0);
    access(1'b1, 5'h05, 32'h12345678, 2, 0);
    access(1'b0, 5'h05, '0, 1, 0);
    access(1'b0, 5'h09, '0, 0, 0);
    access(1'b0, 5'h05, '0, 1, 1);
    access(1'b1, 5'h11, 32'hA5A5_0011, 1, 0);
    access(1'b0, 5'h11, '0, 2, 0);
  endtask

  task automatic test_flush();
    bit bad;
    flush = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'h09;
    #1;
    checks++;
    if (cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b want 0", cpu_ready);
    end
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || cpu_ack !== 1'b0 || cpu_ready !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL flush_ignores_req: request taken alongside flush (req=%b ack=%b)", mem_req, cpu_ack);
    end
    for (int i = 0; i < 4; i++) resident[i] = -1;
    access(1'b0, 5'h09, '0, 1, 0);
  endtask

  task automatic test_reset_mid();
    bit seen, bad;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'h0A;
    @(negedge clk);
    cpu_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL fill_start: mem_req not raised within 10 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (mem_req !== 1'b0 || cpu_ack !== 1'b0 || miss_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: req=%b ack=%b miss=%0d want 0 0 0", mem_req, cpu_ack, miss_count);
    end
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    bad = (cpu_ack !== 1'b0);
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack !== 1'b0 || mem_req !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL late_ack: got cpu_ack=%b mem_req=%b want 0 0", cpu_ack, mem_req);
    end
    access(1'b0, 5'h05, '0, 1, 0);
  endtask

  task automatic test_saturate();
    access(1'b0, 5'h03, '0, 0, 0);
    for (int i = 0; i < 5; i++) access(1'b0, 5'h03, '0, 0, 1);
    checks++;
    if (hit_count2 !== 2'd3) begin
      errors++;
      $display("FAIL hit_saturate: got %0d want 3", hit_count2);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [4:0] a;
    for (int n = 0; n < 250; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      access(($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_model[i] = $urandom;
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid();
    test_saturate();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate word cache between a CPU-side request port and the backing `simple_ram`-style memory port.
- Generalises the earlier fixed 5-bit/4-line cache: configurable address/data width and depth.
- Adds:
  - ready/ack handshakes on both sides, so memory latency may vary;
  - write-hit update;
  - single-cycle flush;
  - saturating hit/miss counters.

Parameters:
- ADDR_W, 5, word address width.
- DATA_W, 32, data word width.
- INDEX_W, 2, index bits; the cache holds 2**INDEX_W lines of one word each. Legal range 1..ADDR_W-1.
- CNT_W, 16, width of the hit/miss counters.
- Derived localparam TAG_W = ADDR_W-INDEX_W. Index = addr[INDEX_W-1:0], tag = addr[ADDR_W-1:INDEX_W].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  invalidate all lines (sampled only in IDLE).
- cpu_req  in  1  request strobe; accepted only on an edge where cpu_ready=1.
- cpu_wr  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_addr  in  ADDR_W  word address; sampled with cpu_req.
- cpu_wdata  in  DATA_W  write data; sampled with cpu_req.
- cpu_ready  out  1  combinational: (state==IDLE) && !flush.
- cpu_ack  out  1  registered one-cycle completion pulse.
- cpu_rdata  out  DATA_W  registered read data; valid while cpu_ack=1, held afterwards.
- mem_req  out  1  registered memory request, held until mem_ack.
- mem_wr  out  1  registered memory write enable.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_ack  in  1  memory completion; meaningful only while mem_req=1.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack on reads.
- hit_count  out  CNT_W  saturating count of read+write hits.
- miss_count  out  CNT_W  saturating count of read+write misses.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; all valid bits cleared.
  - cpu_ack, cpu_rdata, mem_req, mem_wr, mem_addr, mem_wdata, hit_count and miss_count all go to 0.
  - Reset mid-operation abandons the transaction. A later mem_ack is ignored because mem_req=0.
  - Data and tag arrays are not reset.
- IDLE:
  - flush=1 clears every valid bit at that edge; cpu_req is ignored that cycle.
  - Otherwise, if cpu_req=1: latch wr/addr/wdata and go to LOOKUP.
- LOOKUP (one cycle): hit = valid[idx] && tag_array[idx]==tag. Exactly one counter increments, saturating at all-ones.
  - Read hit: cpu_rdata<=data[idx], cpu_ack<=1, go to IDLE. Latency: request edge N -> ack high in the cycle after edge N+1.
  - Read miss: mem_req<=1, mem_wr<=0, mem_addr<=addr, go to FILL.
  - Write, hit or miss: mem_req<=1, mem_wr<=1, mem_addr/mem_wdata<=latched values, go to WTHRU. On a hit, data[idx]<=wdata in the same edge. On a miss, the line is untouched (no allocate).
- FILL:
  - Wait for mem_ack.
  - At the mem_ack edge: data[idx]<=mem_rdata, tag[idx]<=tag, valid[idx]<=1, cpu_rdata<=mem_rdata, cpu_ack<=1, mem_req<=0, go to IDLE.
- WTHRU: at the mem_ack edge: cpu_ack<=1, mem_req<=0, mem_wr<=0, go to IDLE.
- cpu_ack defaults to 0 on every edge where it is not set, so it is exactly one cycle wide.
- mem_ack arriving the same cycle mem_req first rises is legal. The earliest completion is then the next edge.
- Only one outstanding transaction. cpu_req while cpu_ready=0 is dropped, not queued.
- Read-after-write to the same address returns the new data, from the line on a write-hit or from memory on a write-miss.
- Index wrap: addresses differing only in tag evict each other on read fills.

Decomposition:
- Shared package `cache_pkg`:
  - state enum {IDLE, LOOKUP, FILL, WTHRU};
  - defaults for ADDR_W/DATA_W/INDEX_W/CNT_W.
- Sub-module `sat_counter` (parameter W; ports clk, rst, inc, count), instantiated twice for the hit and miss counters.
- Tag/valid/data arrays stay inline in dm_cache_ctrl.

Test Plan:
- Reset, then read 0x05 with mem_rdata=0xDEADBEEF and mem_ack 3 cycles after mem_req -> cpu_ack pulse with cpu_rdata=0xDEADBEEF; miss_count=1.
- Read 0x05 again -> no mem_req; cpu_ack in the cycle after the second edge with 0xDEADBEEF; hit_count=1.
- Write 0x05=0x12345678 -> mem_req/mem_wr with mem_addr=0x05, mem_wdata=0x12345678; after mem_ack, read 0x05 -> hit returning 0x12345678.
- Read 0x09 (same index 1, tag 2) -> miss and fill; then read 0x05 -> miss (evicted); miss_count increments each time.
- Pulse flush in IDLE, then read 0x09 -> miss. Assert rst while in FILL -> mem_req=0 next cycle; late mem_ack produces no cpu_ack.
- Force CNT_W=2 and issue 5 hits -> hit_count saturates at 3.
